// File: rtl/debounce_pkg.sv
// Shared types for the button debouncer and anything that inspects its filter state.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW,
        WAIT_HIGH,
        STABLE_HIGH,
        WAIT_LOW
    } db_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer chain for a single asynchronous bit.
// Latency STAGES cycles; no backpressure.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Turns a bouncy asynchronous button into a clean level plus one-cycle rise/fall pulses.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES-1 edges from input change to output; no backpressure.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall
);

    localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic                 btn_sync;
    db_state_t            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 level_q, level_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (btn_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // cnt counts consecutive samples that disagree with the accepted level,
    // so it starts at 1 on the first disagreeing sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                if (btn_sync) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!btn_sync) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!btn_sync) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (btn_sync) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    assign btn_level = level_q;
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Randomized and directed stimulus for button_debouncer, checked by a queue-based scoreboard.
module tb_button_debouncer;

    localparam int SS = 2;
    localparam int DC = 4;
    localparam int MAXE = 8192;

    logic clk = 1'b1;
    logic rst;
    logic btn_in;
    logic btn_level, btn_rise, btn_fall;

    always #5 clk = ~clk;

    button_debouncer #(
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall)
    );

    typedef struct {
        int e;
        bit rise;
    } pulse_t;

    pulse_t exp_q[$];

    int compared   = 0;
    int mismatched = 0;
    int edge_cnt   = 0;
    int n_modeled  = 0;

    // Reference model: the debounced level flips once DC consecutive
    // synchronized samples disagree with it; samples reach the filter SS edges
    // after capture and a reset wipes everything in flight.
    bit samp    [MAXE];
    bit exp_lvl [MAXE];
    int last_rst = -100;
    bit m_level  = 1'b0;
    int m_run    = 0;
    int exp_cnt  = 0;

    logic [3:0] dut_cnt = 4'd0;

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (btn_rise) dut_cnt <= dut_cnt + 4'd1;
    end

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_cnt - 1, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit b);
        int e;
        bit s;
        @(negedge clk);
        rst    = r;
        btn_in = b;
        e      = edge_cnt;
        samp[e] = r ? 1'b0 : b;
        if (r) begin
            last_rst = e;
            m_level  = 1'b0;
            m_run    = 0;
        end else begin
            s = (e >= SS && last_rst <= e - SS) ? samp[e - SS] : 1'b0;
            if (s != m_level) m_run++;
            else m_run = 0;
            if (m_run == DC) begin
                m_level = ~m_level;
                m_run   = 0;
                exp_q.push_back('{e, m_level});
                if (m_level) exp_cnt++;
            end
        end
        exp_lvl[e] = m_level;
        n_modeled  = e + 1;
    endtask

    task automatic hold(input bit r, input bit b, input int n);
        for (int i = 0; i < n; i++) step(r, b);
    endtask

    // Monitor: checks the level every cycle and matches each pulse against the queue.
    initial begin
        int idx;
        pulse_t p;
        forever begin
            @(negedge clk);
            #1;
            if (edge_cnt >= 1 && edge_cnt - 1 < n_modeled) begin
                idx = edge_cnt - 1;
                chk("btn_level", int'(btn_level), int'(exp_lvl[idx]));
                if (btn_rise && btn_fall) chk("rise_fall_exclusive", 1, 0);
                if (btn_rise || btn_fall) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse_rise", int'(btn_rise), 0);
                    end else begin
                        p = exp_q.pop_front();
                        chk("pulse_edge", idx, p.e);
                        chk("pulse_is_rise", int'(btn_rise), int'(p.rise));
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0] cnt_before;
        int len;
        bit b;
        rst    = 1'b1;
        btn_in = 1'b0;

        // Reset with a toggling input, then idle low.
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        hold(1'b0, 1'b0, 8);

        // Clean press advances the downstream counter by exactly one.
        cnt_before = dut_cnt;
        hold(1'b0, 1'b1, 10);
        chk("clean_press_count", int'(dut_cnt), int'(cnt_before + 4'd1));

        // Release.
        hold(1'b0, 1'b0, 10);

        // Bounce then sustained press.
        cnt_before = dut_cnt;
        step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
        step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
        hold(1'b0, 1'b1, 10);
        chk("bounce_press_count", int'(dut_cnt), int'(cnt_before + 4'd1));
        hold(1'b0, 1'b0, 10);

        // Three-cycle glitch must be rejected.
        cnt_before = dut_cnt;
        hold(1'b0, 1'b1, 3);
        hold(1'b0, 1'b0, 10);
        chk("glitch_count", int'(dut_cnt), int'(cnt_before));

        // Reset two cycles into the high debounce window, input held high.
        hold(1'b0, 1'b1, 4);
        hold(1'b1, 1'b1, 2);
        hold(1'b0, 1'b1, 10);
        hold(1'b0, 1'b0, 10);

        // Random runs of varying length with occasional resets.
        while (n_modeled < 2500) begin
            if ($urandom_range(0, 39) == 0) begin
                len = $urandom_range(1, 3);
                for (int i = 0; i < len; i++) step(1'b1, 1'($urandom_range(0, 1)));
            end else begin
                len = $urandom_range(1, 2 * DC + 2);
                b   = 1'($urandom_range(0, 1));
                hold(1'b0, b, len);
            end
        end
        hold(1'b0, 1'b0, 12);

        @(negedge clk);
        #2;
        chk("pending_pulses", exp_q.size(), 0);
        chk("rise_counter", int'(dut_cnt), int'(4'(exp_cnt)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
